data_mem_unit: RTL and testbench
================================

# data_mem_unit

Data-memory stage of the single-cycle core. Sits directly downstream of the controller/ALU. It consumes `memWrite`/`memRead`, the ALU-computed address and the RS2 store data, and returns load data one cycle later, which the controller's one-cycle load wait state absorbs. The backing array is single-ported. A one-entry store buffer, with store-to-load forwarding, keeps stores from ever stalling the core.

## Interface
Parameters:
- DATA_WIDTH, 8, width of one memory word and of the load/store data.
- ADDR_WIDTH, 8, address width; array depth is 2**ADDR_WIDTH words.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low; sampled on rising edge of clk.
- memRead  input  1  load request this cycle (LW).
- memWrite  input  1  store request this cycle (SW).
- addr  input  ADDR_WIDTH  word address from ALU result.
- wdata  input  DATA_WIDTH  store data (RS2 value).
- rdata  output  DATA_WIDTH  load result.
- rvalid  output  1  one-cycle pulse: rdata carries a fresh load result.
- sb_valid  output  1  store buffer holds an uncommitted store.
- err  output  1  sticky flag: memRead and memWrite were both seen in one cycle.

## Operation
- Single-port array: at most one array access (read or write) per cycle. The array itself is not reset.
- The store buffer holds one entry: sb_valid, sb_addr, sb_data.
- Priority per cycle, evaluated on inputs and current state:
  - reset low: sb_valid<=0, rvalid<=0, rdata<=0, err<=0. A pending buffered store is discarded, never written.
  - memRead&memWrite: err<=1; treated as a store only; no load issued, so rvalid stays 0 next cycle.
  - memWrite:
    - If sb_valid and sb_addr==addr: coalesce; sb_data<=wdata, no array write.
    - If sb_valid and sb_addr!=addr: array[sb_addr]<=sb_data (drain), then buffer<=(addr,wdata).
    - If !sb_valid: buffer<=(addr,wdata), sb_valid<=1.
  - memRead: the load owns the port; the buffer is held, not drained.
    - If sb_valid and sb_addr==addr: next-cycle rdata<=sb_data (forward); the array is not read.
    - Otherwise: rdata<=array[addr].
    - In both cases rvalid<=1 next cycle.
  - Neither request and sb_valid: drain; array[sb_addr]<=sb_data, sb_valid<=0.
  - Neither request and !sb_valid: idle.
- rdata holds its last value when rvalid=0.
- Address is used as-is: the full ADDR_WIDTH range is valid and there is no wrap logic beyond the natural width.
- Forwarding compares against the buffer state at the start of the cycle. A store and a load cannot occur in the same cycle, so there is no same-cycle forwarding case.

## Timing
- Load latency is 1. Request in cycle N gives rdata/rvalid valid in cycle N+1; rvalid is high for exactly one cycle per load.
- Back-to-back loads in N and N+1 give rvalid high in N+1 and N+2, each with its own data.
- A store is committed to the array no earlier than the next idle cycle or the next store to a different address.
- A store is architecturally visible to a load issued in the very next cycle via forwarding.
- The buffer drains in one cycle. sb_valid falls in the cycle after the drain cycle.
- A continuous load stream may hold the buffer indefinitely; correctness is preserved by forwarding.
- Reset is honoured mid-operation. A load issued in the reset cycle produces no rvalid, and any buffered store is lost.
- Reset values: rdata=0, rvalid=0, sb_valid=0, err=0.

## Test plan
- Reset, then store addr=0x10 data=0xA5, then idle cycle. Required: sb_valid falls one cycle after the idle cycle. A later load of 0x10 returns rdata=0xA5 with rvalid=1 exactly one cycle after the request.
- Store 0x20←0x3C, immediately load 0x20. Required: rdata=0x3C (forwarded), rvalid=1 in the next cycle, and sb_valid still 1.
- Store 0x30←0x11, then store 0x30←0x22 back-to-back, idle, load 0x30. Required: rdata=0x22 and exactly one array write to 0x30.
- Store 0x40←0x01, store 0x41←0x02, load 0x40, load 0x41. Required: rdata=0x01 then 0x02 on consecutive cycles. The first value comes from the array after the drain; the second is forwarded.
- Store 0x50←0x77, then drive reset low for one cycle before any idle cycle, then load 0x50. Required: sb_valid=0 after reset and rdata equals the pre-existing array content, not 0x77.
- Assert memRead=memWrite=1 with addr 0x60, data 0x99. Required: err=1 and stays 1, rvalid=0 the next cycle, and a later load of 0x60 returns 0x99.

Source files
------------

// File: rtl/data_mem_unit_if.sv
// ----------------------------------------------------------------------------
// data_mem_unit_if
// Load/store bus between the core (controller/ALU) and the data-memory stage.
//
// Signals:
//   memRead   core -> mem  load request this cycle
//   memWrite  core -> mem  store request this cycle
//   addr      core -> mem  word address
//   wdata     core -> mem  store data
//   rdata     mem -> core  load result, held while rvalid is low
//   rvalid    mem -> core  one-cycle pulse per completed load
//   sb_valid  mem -> core  store buffer holds an uncommitted store
//   err       mem -> core  sticky: load and store requested together
//
// Modports: master (core side), slave (memory side).
// ----------------------------------------------------------------------------
interface data_mem_unit_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
) ();
    logic                  memRead;
    logic                  memWrite;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  sb_valid;
    logic                  err;

    modport master (
        output memRead,
        output memWrite,
        output addr,
        output wdata,
        input  rdata,
        input  rvalid,
        input  sb_valid,
        input  err
    );

    modport slave (
        input  memRead,
        input  memWrite,
        input  addr,
        input  wdata,
        output rdata,
        output rvalid,
        output sb_valid,
        output err
    );
endinterface

// File: rtl/data_mem_unit.sv
// ----------------------------------------------------------------------------
// data_mem_unit
// Data-memory stage with a single-ported array, one-cycle load latency and a
// one-entry store buffer with store-to-load forwarding, so stores never stall.
//
// Ports:
//   clk    core clock, all state updates on the rising edge
//   reset  synchronous, active-low
//   bus    data_mem_unit_if.slave (memRead, memWrite, addr, wdata in;
//          rdata, rvalid, sb_valid, err out)
//
// Per-cycle priority: reset > store (including the illegal load+store) >
// load > drain of a buffered store when idle.
// ----------------------------------------------------------------------------
module data_mem_unit #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input logic              clk,
    input logic              reset,
    data_mem_unit_if.slave   bus
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    // Backing array, deliberately not reset.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Store buffer.
    logic                  r_sb_valid;
    logic [ADDR_WIDTH-1:0] r_sb_addr;
    logic [DATA_WIDTH-1:0] r_sb_data;

    // Registered outputs.
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rvalid;
    logic                  r_err;

    logic                  w_store;
    logic                  w_load;
    logic                  w_idle;
    logic                  w_sb_hit;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_waddr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic [DATA_WIDTH-1:0] w_load_data;

    // A simultaneous load+store is handled as a store only.
    assign w_store  = bus.memWrite;
    assign w_load   = bus.memRead & ~bus.memWrite;
    assign w_idle   = ~bus.memRead & ~bus.memWrite;

    // Hit test uses buffer state from the start of the cycle.
    assign w_sb_hit = r_sb_valid && (r_sb_addr == bus.addr);

    // The port is free for a drain on an idle cycle, or on a store that
    // displaces the buffered entry. Loads own the port, so the buffer waits.
    // Reset suppresses the drain: a pending store is dropped, never written.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = r_sb_addr;
        w_mem_wdata = r_sb_data;
        if (reset && r_sb_valid) begin
            if (w_idle) begin
                w_mem_we = 1'b1;
            end else if (w_store && !w_sb_hit) begin
                w_mem_we = 1'b1;
            end
        end
    end

    // Forwarding replaces the array read entirely on a hit.
    assign w_load_data = w_sb_hit ? r_sb_data : r_mem[bus.addr];

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sb_valid <= 1'b0;
            r_sb_addr  <= '0;
            r_sb_data  <= '0;
            r_rdata    <= '0;
            r_rvalid   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rvalid <= w_load;
            if (bus.memRead && bus.memWrite) begin
                r_err <= 1'b1;
            end
            if (w_store) begin
                // Covers coalesce, displace-after-drain and fill-empty alike.
                r_sb_valid <= 1'b1;
                r_sb_addr  <= bus.addr;
                r_sb_data  <= bus.wdata;
            end else if (w_load) begin
                r_rdata <= w_load_data;
            end else if (r_sb_valid) begin
                r_sb_valid <= 1'b0;
            end
        end
    end

    assign bus.rdata    = r_rdata;
    assign bus.rvalid   = r_rvalid;
    assign bus.sb_valid = r_sb_valid;
    assign bus.err      = r_err;

endmodule

// File: tb/tb_data_mem_unit.sv
// ----------------------------------------------------------------------------
// tb_data_mem_unit
// Driver applies one request per cycle on the falling edge and pushes the
// expected responses into queues; a monitor on the falling edge pops and
// compares. The reference model is an architectural memory plus a pending
// store that is committed on idle cycles or on a store to another address.
// ----------------------------------------------------------------------------
module tb_data_mem_unit;

    localparam int  DW  = 8;
    localparam int  AW  = 8;
    localparam time PER = 10;

    typedef struct {
        longint         t;
        logic [DW-1:0]  data;
    } load_exp_t;

    typedef struct {
        longint         t;
        logic           sb;
        logic           er;
        logic [DW-1:0]  rd;
    } stat_exp_t;

    logic clk;
    logic reset;

    data_mem_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    data_mem_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #(PER / 2) clk = ~clk;

    // Reference model state.
    logic [DW-1:0] m_mem [2 ** AW];
    logic          m_pend_v;
    logic [AW-1:0] m_pend_a;
    logic [DW-1:0] m_pend_d;
    logic          m_err;
    logic [DW-1:0] m_rdata;

    load_exp_t lq[$];
    stat_exp_t sq[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Array writes to 0x30, observed at the array port.
    int wr30_total = 0;
    always @(posedge clk) begin
        if (dut.w_mem_we && dut.w_mem_waddr == 8'h30) wr30_total <= wr30_total + 1;
    end

    // One request per cycle; updates the model and queues what must appear
    // at the next falling edge.
    task automatic drive(input logic rst_n, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        load_exp_t le;
        stat_exp_t se;
        @(negedge clk);
        reset        = rst_n;
        bus.memRead  = rd;
        bus.memWrite = wr;
        bus.addr     = a;
        bus.wdata    = d;
        if (!rst_n) begin
            m_pend_v = 1'b0;
            m_err    = 1'b0;
            m_rdata  = '0;
        end else if (wr) begin
            if (rd) m_err = 1'b1;
            if (m_pend_v && m_pend_a != a) m_mem[m_pend_a] = m_pend_d;
            m_pend_v = 1'b1;
            m_pend_a = a;
            m_pend_d = d;
        end else if (rd) begin
            m_rdata = (m_pend_v && m_pend_a == a) ? m_pend_d : m_mem[a];
            le.t    = longint'($time + PER);
            le.data = m_rdata;
            lq.push_back(le);
        end else if (m_pend_v) begin
            m_mem[m_pend_a] = m_pend_d;
            m_pend_v        = 1'b0;
        end
        se.t  = longint'($time + PER);
        se.sb = m_pend_v;
        se.er = m_err;
        se.rd = m_rdata;
        sq.push_back(se);
    endtask

    task automatic st(input logic [AW-1:0] a, input logic [DW-1:0] d);
        drive(1'b1, 1'b0, 1'b1, a, d);
    endtask

    task automatic ld(input logic [AW-1:0] a);
        drive(1'b1, 1'b1, 1'b0, a, '0);
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic rst_cycle();
        drive(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // Monitor.
    always @(negedge clk) begin
        stat_exp_t se;
        load_exp_t le;
        if (sq.size() > 0 && sq[0].t == longint'($time)) begin
            se = sq.pop_front();
            n_tests++;
            if (bus.sb_valid !== se.sb || bus.err !== se.er || bus.rdata !== se.rd) begin
                n_fail++;
                $display("FAIL status @%0t: sb_valid=%b err=%b rdata=%h required %b %b %h",
                         $time, bus.sb_valid, bus.err, bus.rdata, se.sb, se.er, se.rd);
            end
        end
        if (lq.size() > 0 && lq[0].t == longint'($time)) begin
            le = lq.pop_front();
            n_tests++;
            if (bus.rvalid !== 1'b1) begin
                n_fail++;
                $display("FAIL load_valid @%0t: rvalid=%b required 1", $time, bus.rvalid);
            end else if (bus.rdata !== le.data) begin
                n_fail++;
                $display("FAIL load_data @%0t: rdata=%h required %h", $time, bus.rdata, le.data);
            end
        end else if (bus.rvalid === 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL spurious_rvalid @%0t: rvalid=1 required 0", $time);
        end
    end

    // Hard time bound.
    initial begin
        #(PER * 20000);
        $display("FAIL timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int w0;
        reset        = 1'b0;
        bus.memRead  = 1'b0;
        bus.memWrite = 1'b0;
        bus.addr     = '0;
        bus.wdata    = '0;
        m_pend_v     = 1'b0;
        m_pend_a     = '0;
        m_pend_d     = '0;
        m_err        = 1'b0;
        m_rdata      = '0;

        rst_cycle();
        rst_cycle();

        // Give every array word a known value.
        for (int i = 0; i < 2 ** AW; i++) st(AW'(i), DW'($urandom));
        idle();
        idle();

        // Store, idle drain, later load.
        st(8'h10, 8'hA5);
        idle();
        idle();
        ld(8'h10);
        idle();

        // Forward to an immediate load.
        st(8'h20, 8'h3C);
        ld(8'h20);

        // Coalesce: exactly one array write to 0x30.
        w0 = wr30_total;
        st(8'h30, 8'h11);
        st(8'h30, 8'h22);
        idle();
        ld(8'h30);
        idle();
        @(negedge clk);
        n_tests++;
        if (wr30_total - w0 != 1) begin
            n_fail++;
            $display("FAIL coalesce_writes: writes=%0d required 1", wr30_total - w0);
        end

        // Drain on displacing store, then array read then forward.
        st(8'h40, 8'h01);
        st(8'h41, 8'h02);
        ld(8'h40);
        ld(8'h41);
        idle();

        // Reset drops the pending store.
        st(8'h50, 8'h77);
        rst_cycle();
        ld(8'h50);
        idle();

        // Illegal load+store: err sticky, treated as store.
        drive(1'b1, 1'b1, 1'b1, 8'h60, 8'h99);
        idle();
        idle();
        ld(8'h60);
        idle();

        // Randomized traffic over a small address window to get many hits.
        for (int i = 0; i < 600; i++) begin
            int unsigned r;
            logic [AW-1:0] a;
            r = $urandom_range(0, 99);
            a = {5'b10000, 3'($urandom_range(0, 7))};
            if (r < 35)      ld(a);
            else if (r < 70) st(a, DW'($urandom));
            else if (r < 93) idle();
            else if (r < 97) drive(1'b1, 1'b1, 1'b1, a, DW'($urandom));
            else             rst_cycle();
        end
        idle();

        // Let the last expectations come due.
        @(negedge clk);
        @(negedge clk);
        #1;
        n_tests++;
        if (lq.size() != 0 || sq.size() != 0) begin
            n_fail++;
            $display("FAIL drain_queues: pending=%0d required 0", lq.size() + sq.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
